// File: rtl/inst_mem_responder_pkg.sv
// rtl/inst_mem_responder_pkg.sv - shared fetch constants, responder state type and address check
package inst_mem_responder_pkg;

    localparam logic [31:0] RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam int          INST_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imr_state_e;

    // Offset is taken in 32 bits; the explicit below-base test keeps wrapped addresses out of the store.
    function automatic logic fetch_fault(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || (off >= span);
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - word store with synchronous write and combinational read
module inst_mem_array
    import inst_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [INST_W-1:0] rdata_o
);

    logic [INST_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // Read sees pre-edge contents, so a same-edge write never leaks into the response.
    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction-fetch responder with fixed latency and fault reporting
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = RESET_PC,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_fault,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    imr_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;

    logic [31:0]       rd_addr;
    logic              rd_fault;
    logic [IDX_W-1:0]  rd_idx;
    logic [INST_W-1:0] rd_data;
    logic [31:0]       ld_word;
    logic              ld_we;
    logic [IDX_W-1:0]  ld_idx;
    logic              enter_resp;

    // With LATENCY==1 the read happens on the accept edge, so it must use the live request address.
    assign rd_addr  = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_fault = fetch_fault(rd_addr, ADDR_BASE, SPAN);
    assign rd_idx   = IDX_W'((rd_addr - ADDR_BASE) >> 2);

    assign ld_word  = ld_addr & 32'hFFFF_FFFC;
    assign ld_we    = ld_en && !fetch_fault(ld_word, ADDR_BASE, SPAN);
    assign ld_idx   = IDX_W'((ld_word - ADDR_BASE) >> 2);

    inst_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .we_i   (ld_we),
        .widx_i (ld_idx),
        .wdata_i(ld_data),
        .ridx_i (rd_idx),
        .rdata_o(rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = CNT_INIT;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d = RESP;
            inst_d  = rd_fault ? '0 : rd_data;
            fault_d = rd_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_inst  = inst_q;
    assign resp_fault = fault_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - self-checking bench for three latency configurations of the fetch responder
module tb_inst_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [31:0] req_addr [3];
    logic [2:0]  resp_valid;
    logic [2:0]  resp_ready;
    logic [31:0] resp_inst [3];
    logic [2:0]  resp_fault;
    logic [2:0]  ld_en;
    logic [31:0] ld_addr [3];
    logic [31:0] ld_data [3];

    logic [31:0] mdl [3][DEPTH];
    int          lat_of [3] = '{1, 3, 4};
    logic [31:0] prog [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0031_0193, 32'h0010_0073};
    int          errors = 0;
    int          checks = 0;

    inst_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_inst(resp_inst[0]), .resp_fault(resp_fault[0]), .ld_en(ld_en[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

    inst_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_inst(resp_inst[1]), .resp_fault(resp_fault[1]), .ld_en(ld_en[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

    inst_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_inst(resp_inst[2]), .resp_fault(resp_fault[2]), .ld_en(ld_en[2]),
        .ld_addr(ld_addr[2]), .ld_data(ld_data[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_fault(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (a % 4 != 0) || (ua < longint'(BASE)) || (ua >= longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic logic [31:0] exp_inst(input int d, input logic [31:0] a);
        if (exp_fault(a)) return 32'h0;
        return mdl[d][(a - BASE) / 4];
    endfunction

    // Presents one request from an idle DUT and completes the handshake as soon as the response appears.
    task automatic fetch(input int d, input logic [31:0] a, output int lat,
                         output logic [31:0] inst, output logic flt, output bit busy_ok);
        busy_ok = 1;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            if (req_ready[d]) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
        if (req_ready[d]) busy_ok = 0;
        inst = resp_inst[d];
        flt  = resp_fault[d];
        @(negedge clk);
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 3'b111; req_valid = '0; resp_ready = '0; ld_en = '0;
        for (int d = 0; d < 3; d++) begin
            req_addr[d] = '0; ld_addr[d] = '0; ld_data[d] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 3'b000;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({req_ready[d], resp_valid[d], resp_fault[d], resp_inst[d]} !== {3'b100, 32'h0}) begin
                errors++;
                $display("FAIL reset[%0d] got rdy=%b vld=%b flt=%b inst=%h exp rdy=1 vld=0 flt=0 inst=0",
                         d, req_ready[d], resp_valid[d], resp_fault[d], resp_inst[d]);
            end
        end
    endtask

    task automatic test_preload();
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = (i < 4) ? prog[i] : $urandom;
            ld_en = 3'b111;
            for (int d = 0; d < 3; d++) begin
                ld_addr[d] = BASE + 32'(4 * i);
                ld_data[d] = v;
                mdl[d][i]  = v;
            end
            @(negedge clk);
        end
        ld_en = 3'b000;
    endtask

    task automatic test_sequence_l1();
        int lat; logic [31:0] inst; logic flt; bit busy_ok;
        for (int i = 0; i < 4; i++) begin
            fetch(0, BASE + 32'(4 * i), lat, inst, flt, busy_ok);
            checks++;
            if (inst !== prog[i] || flt !== 1'b0) begin
                errors++;
                $display("FAIL seq_data[%0d] got inst=%h flt=%b exp inst=%h flt=0", i, inst, flt, prog[i]);
            end
            checks++;
            if (lat != 1 || !busy_ok) begin
                errors++;
                $display("FAIL seq_timing[%0d] got lat=%0d busy_ok=%0d exp lat=1 busy_ok=1", i, lat, busy_ok);
            end
        end
    endtask

    task automatic test_latency_hold();
        int lat; logic [31:0] held; bit ok;
        req_valid[1] = 1'b1; req_addr[1] = BASE + 32'h4; resp_ready[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b0;
        lat = 1;
        while (!resp_valid[1] && lat < 40) begin @(negedge clk); lat++; end
        held = resp_inst[1];
        checks++;
        if (lat != 3 || held !== 32'h0020_0113) begin
            errors++;
            $display("FAIL hold_first got lat=%0d inst=%h exp lat=3 inst=00200113", lat, held);
        end
        ok = 1;
        for (int k = 0; k < 4; k++) begin
            req_valid[1] = 1'b1; req_addr[1] = BASE + 32'h8;
            @(negedge clk);
            if (!resp_valid[1] || req_ready[1] || resp_inst[1] !== held || resp_fault[1]) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_stable got vld=%b rdy=%b inst=%h exp vld=1 rdy=0 inst=%h",
                     resp_valid[1], req_ready[1], resp_inst[1], held);
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        checks++;
        if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", resp_valid[1], req_ready[1]);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_accept got rdy=%b exp rdy=0", req_ready[1]);
        end
        lat = 1;
        while (!resp_valid[1] && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 3 || resp_inst[1] !== mdl[1][2]) begin
            errors++;
            $display("FAIL hold_second got lat=%0d inst=%h exp lat=3 inst=%h", lat, resp_inst[1], mdl[1][2]);
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
    endtask

    task automatic test_faults();
        logic [31:0] addrs [4] = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC, 32'hFFFF_FFFC};
        int lat; logic [31:0] inst; logic flt; bit busy_ok;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                fetch(d, addrs[i], lat, inst, flt, busy_ok);
                checks++;
                if (flt !== 1'b1 || inst !== 32'h0 || lat != lat_of[d]) begin
                    errors++;
                    $display("FAIL fault[%0d][%h] got flt=%b inst=%h lat=%0d exp flt=1 inst=0 lat=%0d",
                             d, addrs[i], flt, inst, lat, lat_of[d]);
                end
            end
        end
    endtask

    task automatic test_collision();
        int lat; logic [31:0] inst; logic flt; bit busy_ok; logic [31:0] old;
        old = mdl[0][0];
        ld_en[0] = 1'b1; ld_addr[0] = BASE; ld_data[0] = 32'hDEAD_BEEF;
        fetch(0, BASE, lat, inst, flt, busy_ok);
        ld_en[0] = 1'b0;
        mdl[0][0] = 32'hDEAD_BEEF;
        checks++;
        if (inst !== old || flt !== 1'b0) begin
            errors++;
            $display("FAIL collision_old got inst=%h flt=%b exp inst=%h flt=0", inst, flt, old);
        end
        // Out-of-range preload must be dropped, not wrapped onto word 0; low address bits are ignored.
        ld_en[0] = 1'b1; ld_addr[0] = BASE + 32'h1000; ld_data[0] = 32'h1234_5678;
        @(negedge clk);
        ld_addr[0] = BASE + 32'h7; ld_data[0] = 32'hCAFE_F00D;
        mdl[0][1] = 32'hCAFE_F00D;
        @(negedge clk);
        ld_en[0] = 1'b0;
        fetch(0, BASE, lat, inst, flt, busy_ok);
        checks++;
        if (inst !== exp_inst(0, BASE)) begin
            errors++;
            $display("FAIL collision_new got inst=%h exp inst=%h", inst, exp_inst(0, BASE));
        end
        fetch(0, BASE + 32'h4, lat, inst, flt, busy_ok);
        checks++;
        if (inst !== exp_inst(0, BASE + 32'h4)) begin
            errors++;
            $display("FAIL preload_lowbits got inst=%h exp inst=%h", inst, exp_inst(0, BASE + 32'h4));
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] inst; logic flt; bit busy_ok; bit quiet;
        fetch(2, BASE + 32'h8, lat, inst, flt, busy_ok);
        checks++;
        if (inst !== prog[2] || lat != 4 || !busy_ok) begin
            errors++;
            $display("FAIL l4_fetch got inst=%h lat=%0d busy_ok=%0d exp inst=%h lat=4 busy_ok=1",
                     inst, lat, busy_ok, prog[2]);
        end
        req_valid[2] = 1'b1; req_addr[2] = BASE + 32'h4;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        checks++;
        if ({req_ready[2], resp_valid[2], resp_fault[2], resp_inst[2]} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL midreset got rdy=%b vld=%b flt=%b inst=%h exp rdy=1 vld=0 flt=0 inst=0",
                     req_ready[2], resp_valid[2], resp_fault[2], resp_inst[2]);
        end
        quiet = 1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[2] || !req_ready[2]) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midreset_discard got vld=%b rdy=%b exp vld=0 rdy=1", resp_valid[2], req_ready[2]);
        end
        fetch(2, BASE + 32'hC, lat, inst, flt, busy_ok);
        checks++;
        if (inst !== 32'h0010_0073 || flt !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL midreset_retain got inst=%h flt=%b lat=%0d exp inst=00100073 flt=0 lat=4",
                     inst, flt, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] q_inst [$];
        logic        q_flt [$];
        logic [31:0] a, e_inst;
        logic        e_flt;
        int acc = 0, got = 0, cyc = 0, r;
        while ((acc < 200 || q_inst.size() != 0) && cyc < 20000) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 8) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else             a = $urandom;
            req_valid[1]  = (acc < 200) && ($urandom_range(0, 2) != 0);
            req_addr[1]   = a;
            resp_ready[1] = ($urandom_range(0, 3) != 0);
            if (req_valid[1] && req_ready[1]) begin
                q_inst.push_back(exp_inst(1, a));
                q_flt.push_back(exp_fault(a));
                acc++;
            end
            if (resp_valid[1] && resp_ready[1]) begin
                got++;
                checks++;
                if (q_inst.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra got response %0d with inst=%h exp none outstanding",
                             got, resp_inst[1]);
                end else begin
                    e_inst = q_inst.pop_front();
                    e_flt  = q_flt.pop_front();
                    if (resp_inst[1] !== e_inst || resp_fault[1] !== e_flt) begin
                        errors++;
                        $display("FAIL rand_resp[%0d] got inst=%h flt=%b exp inst=%h flt=%b",
                                 got, resp_inst[1], resp_fault[1], e_inst, e_flt);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[1] = 1'b0;
        resp_ready[1] = 1'b0;
        checks++;
        if (acc != 200 || got != 200 || q_inst.size() != 0) begin
            errors++;
            $display("FAIL rand_count got acc=%0d resp=%0d pending=%0d exp 200/200/0",
                     acc, got, q_inst.size());
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_sequence_l1();
        test_latency_hold();
        test_faults();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
